// File: rtl/alu_transpose_stream.sv
// Row-streamed n x n matrix buffer: loads n rows, then emits them transposed or
// unchanged. Both sides use valid/ready; n and mode are latched when a job starts.
module alu_transpose_stream #(
    parameter int DIM = 5,
    parameter int W   = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_mode,
    input  logic [$clog2(DIM+1)-1:0] i_size,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [DIM*W-1:0]         i_in_row,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [DIM*W-1:0]         o_out_row,
    output logic                     o_busy,
    output logic                     o_done
);
    localparam int CW = $clog2(DIM + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_mode;
    logic [CW-1:0] r_n;
    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic [W-1:0]  r_mem [DIM][DIM];

    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_last_row;
    logic          w_job_start;
    logic [CW-1:0] w_size_eff;

    // A size of zero or beyond the buffer means a full DIM x DIM job.
    assign w_size_eff  = (i_size == '0 || i_size > CW'(DIM)) ? CW'(DIM) : i_size;
    assign w_job_start = (r_state == S_IDLE) && i_start;
    assign w_in_fire   = (r_state == S_LOAD) && i_in_valid;
    assign w_out_fire  = (r_state == S_EMIT) && i_out_ready;
    assign w_last_row  = (r_cnt == r_n - CW'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (i_start)                w_next_state = S_LOAD;
            S_LOAD: if (w_in_fire && w_last_row)  w_next_state = S_EMIT;
            S_EMIT: if (w_out_fire && w_last_row) w_next_state = S_IDLE;
            default:                            w_next_state = S_IDLE;
        endcase
    end

    // One row counter serves both phases; it wraps to 0 after the last row.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode <= 1'b0;
            r_n    <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_out_fire && w_last_row;
            if (w_job_start) begin
                r_mode <= i_mode;
                r_n    <= w_size_eff;
                r_cnt  <= '0;
            end else if (w_in_fire || w_out_fire) begin
                r_cnt <= w_last_row ? '0 : r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_job_start) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
        end else if (w_in_fire) begin
            for (int c = 0; c < DIM; c++) begin
                r_mem[r_cnt][c] <= (c < int'(r_n)) ? i_in_row[c*W +: W] : '0;
            end
        end
    end

    // Output row is decoded from registered state only, so it holds during stalls.
    always_comb begin
        o_out_row = '0;
        if (r_state == S_EMIT) begin
            for (int c = 0; c < DIM; c++) begin
                if (c < int'(r_n)) begin
                    o_out_row[c*W +: W] = r_mode ? r_mem[r_cnt][c] : r_mem[c][r_cnt];
                end
            end
        end
    end

    assign o_in_ready  = (r_state == S_LOAD);
    assign o_out_valid = (r_state == S_EMIT);
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;

endmodule

// File: tb/tb_alu_transpose_stream.sv
// Testbench for alu_transpose_stream: table of jobs checked against a row
// scoreboard, plus hand sequences for reset mid-job and back-to-back jobs.
module tb_alu_transpose_stream;
    localparam int DIM = 5;
    localparam int W   = 8;
    localparam int SW  = $clog2(DIM + 1);
    localparam int RW  = DIM * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [SW-1:0] size;
    logic          in_valid;
    logic          o_in_ready;
    logic [RW-1:0] in_row;
    logic          o_out_valid;
    logic          out_ready;
    logic [RW-1:0] o_out_row;
    logic          o_busy;
    logic          o_done;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] expQ[$];

    typedef struct {
        logic          mode;
        logic [SW-1:0] size;
        logic [W-1:0]  base;
        bit            randIn;
        int            outStallAt;
        bit            startInEmit;
        int            expN;
        int            expLat;
        logic [RW-1:0] expRow0;
    } jobRec_t;

    jobRec_t vec[9];
    jobRec_t jobA;
    jobRec_t jobB;

    alu_transpose_stream #(.DIM(DIM), .W(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_mode      (mode),
        .i_size      (size),
        .i_in_valid  (in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_row    (in_row),
        .o_out_valid (o_out_valid),
        .i_out_ready (out_ready),
        .o_out_row   (o_out_row),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] elem(input logic [W-1:0] base, input int r, input int c);
        return W'(int'(base) + r * DIM + c);
    endfunction

    function automatic logic [RW-1:0] inRow(input logic [W-1:0] base, input int r);
        logic [RW-1:0] row;
        row = '0;
        for (int c = 0; c < DIM; c++) row[c*W +: W] = elem(base, r, c);
        return row;
    endfunction

    function automatic logic [RW-1:0] expRow(input logic m, input logic [W-1:0] base,
                                             input int n, input int k);
        logic [RW-1:0] row;
        row = '0;
        for (int c = 0; c < n; c++) row[c*W +: W] = m ? elem(base, k, c) : elem(base, c, k);
        return row;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Starts a job in the current cycle and runs it until done or a cycle budget expires.
    task automatic applyStimulus(input jobRec_t j);
        int n, cyc, accRows, outRows, emitCyc, lat;
        bit gotDone, busyAtDone, prevStall;
        logic [RW-1:0] held;
        n = (j.size == 0 || int'(j.size) > DIM) ? DIM : int'(j.size);
        for (int k = 0; k < n; k++) expQ.push_back(expRow(j.mode, j.base, n, k));
        start = 1'b1; mode = j.mode; size = j.size; in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0; accRows = 0; outRows = 0; emitCyc = 0; lat = 0;
        gotDone = 0; busyAtDone = 1; prevStall = 0; held = '0;
        while (!gotDone && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (o_out_valid) emitCyc++;
            if (j.startInEmit && emitCyc == 2) begin
                start = 1'b1; size = SW'(2); mode = ~j.mode;
            end
            in_valid  = j.randIn ? 1'($urandom_range(0, 1)) : 1'b1;
            in_row    = (accRows < DIM) ? inRow(j.base, accRows) : '0;
            out_ready = !(j.outStallAt >= 0 && emitCyc >= j.outStallAt && emitCyc < j.outStallAt + 4);
            @(negedge clk);
            if (prevStall) checkOutput("stall stable", o_out_row, held);
            if (in_valid && o_in_ready) accRows++;
            if (o_out_valid && out_ready) begin
                if (outRows == 0) checkOutput("row0", o_out_row, j.expRow0);
                if (expQ.size() == 0) begin
                    checkOutput("extra out row", 64'(outRows), 64'(n));
                end else begin
                    checkOutput($sformatf("out row %0d", outRows), o_out_row, expQ.pop_front());
                end
                outRows++;
            end
            prevStall = o_out_valid && !out_ready;
            held = o_out_row;
            if (o_done) begin
                gotDone = 1; lat = cyc; busyAtDone = o_busy;
            end
        end
        in_valid = 1'b0;
        checkOutput("done seen", 64'(gotDone), 64'(1));
        checkOutput("rows accepted", 64'(accRows), 64'(j.expN));
        checkOutput("rows emitted", 64'(outRows), 64'(j.expN));
        checkOutput("busy at done", 64'(busyAtDone), 64'(0));
        checkOutput("rows pending", 64'(expQ.size()), 64'(0));
        if (j.expLat != 0) checkOutput("done latency", 64'(lat), 64'(j.expLat));
        expQ.delete();
    endtask

    initial begin
        bit doneSeen;
        vec[0] = '{1'b0, 3'd5, 8'h00, 1'b0, -1, 1'b0, 5, 11, 40'h140F0A0500};
        vec[1] = '{1'b1, 3'd5, 8'h00, 1'b0, -1, 1'b0, 5, 11, 40'h0403020100};
        vec[2] = '{1'b0, 3'd3, 8'h00, 1'b0, -1, 1'b0, 3, 7,  40'h00000A0500};
        vec[3] = '{1'b1, 3'd3, 8'h00, 1'b0, -1, 1'b0, 3, 7,  40'h0000020100};
        vec[4] = '{1'b0, 3'd0, 8'h00, 1'b0, -1, 1'b0, 5, 11, 40'h140F0A0500};
        vec[5] = '{1'b0, 3'd7, 8'h00, 1'b0, -1, 1'b0, 5, 11, 40'h140F0A0500};
        vec[6] = '{1'b0, 3'd1, 8'h40, 1'b0, -1, 1'b0, 1, 3,  40'h0000000040};
        vec[7] = '{1'b0, 3'd5, 8'h00, 1'b1, 2,  1'b0, 5, 0,  40'h140F0A0500};
        vec[8] = '{1'b0, 3'd5, 8'h00, 1'b0, -1, 1'b1, 5, 11, 40'h140F0A0500};
        jobA   = '{1'b0, 3'd5, 8'h80, 1'b0, -1, 1'b0, 5, 11, 40'h948F8A8580};
        jobB   = '{1'b0, 3'd2, 8'h00, 1'b0, -1, 1'b0, 2, 5,  40'h0000000500};

        rst = 1'b1; start = 1'b0; mode = 1'b0; size = '0;
        in_valid = 1'b0; in_row = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset in_ready", 64'(o_in_ready), 64'(0));
        checkOutput("reset out_valid", 64'(o_out_valid), 64'(0));
        checkOutput("reset out_row", 64'(o_out_row), 64'(0));
        checkOutput("reset busy", 64'(o_busy), 64'(0));
        checkOutput("reset done", 64'(o_done), 64'(0));

        // Abandon a job after two rows with a reset
        idle(1);
        start = 1'b1; mode = 1'b0; size = SW'(5);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy after start", 64'(o_busy), 64'(1));
        checkOutput("in_ready after start", 64'(o_in_ready), 64'(1));
        for (int r = 0; r < 2; r++) begin
            in_valid = 1'b1; in_row = inRow(8'h00, r);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid-job reset busy", 64'(o_busy), 64'(0));
        checkOutput("mid-job reset in_ready", 64'(o_in_ready), 64'(0));
        checkOutput("mid-job reset out_valid", 64'(o_out_valid), 64'(0));
        doneSeen = o_done;
        repeat (3) begin
            @(negedge clk);
            doneSeen |= o_done;
        end
        checkOutput("mid-job reset no done", 64'(doneSeen), 64'(0));

        for (int i = 0; i < 9; i++) begin
            idle(2);
            applyStimulus(vec[i]);
        end

        // Back-to-back: second start lands in the first job's done cycle
        idle(2);
        applyStimulus(jobA);
        applyStimulus(jobB);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_transpose_stream.md
# alu_transpose_stream

Sequential, parametrised successor to the coprocessor's combinational 5x5 transpose. It accepts a square matrix one row per handshake, buffers it internally, and streams it back one row per handshake, either transposed or unchanged. It sits between the matrix load path and the ALU result path. Unlike the flat transpose, it supports a runtime sub-matrix size and valid/ready backpressure on both sides.

## Interface
- DIM, 5: maximum matrix dimension; the buffer is DIM x DIM elements.
- W, 8: element width in bits.
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a job; sampled only in IDLE.
- mode  input  1  0 = transpose, 1 = passthrough; latched on start.
- size  input  $clog2(DIM+1)  active dimension n; latched on start. 0 or >DIM is treated as DIM.
- in_valid  input  1  in_row is valid.
- in_ready  output  1  block accepts a row.
- in_row  input  DIM*W  element c at bits [c*W +: W].
- out_valid  output  1  out_row is valid.
- out_ready  input  1  consumer accepts a row.
- out_row  output  DIM*W  same element layout as in_row.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at job completion.

## Operation
- States: IDLE, LOAD, EMIT.
- IDLE:
  - On start=1: latch mode and n, clear the whole buffer to 0, set row counter to 0, go to LOAD.
  - start while not in IDLE is ignored.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: M[r][c] = in_row element c for c<n. Elements c>=n are discarded and stay 0. r increments.
  - After the row with r=n-1 is accepted: reset the counter to 0 and go to EMIT.
- EMIT:
  - out_valid=1.
  - out_row row k, element c:
    - transpose: M[c][k].
    - passthrough: M[k][c].
    - Element positions c>=n are driven to 0.
  - On out_valid&&out_ready: k increments.
  - After the row with k=n-1 is accepted: go to IDLE and pulse done.
- Only n rows are consumed and n rows produced per job. Rows and columns >= n are never exchanged with the outside.
- out_row must be registered or derived only from registered state: stable while out_valid=1 and out_ready=0.
- in_ready is 0 outside LOAD; out_valid is 0 outside EMIT. in_valid outside LOAD is ignored.

## Timing
- Reset values: state IDLE, in_ready=0, out_valid=0, out_row=0, busy=0, done=0, counters 0. Buffer contents are don't-care until the next start clears them.
- Reset mid-job (any state) returns to IDLE the next edge. No done pulse; the partial job is abandoned.
- start at edge t: busy=1 and in_ready=1 from t+1.
- Last input handshake at edge t: in_ready=0 and out_valid=1 with row 0 from t+1. There is no bubble.
- Best-case job length is 2n+1 cycles from start, with in_valid and out_ready held high: 1 for start, n for load, n for emit.
- Last output handshake at edge t: out_valid=0, busy=0 and done=1 during cycle t+1 only.
- A start asserted in the done cycle is accepted, so back-to-back jobs are possible.
- Zero-latency backpressure: any number of stall cycles on either side leaves the data unchanged.

## Test plan
- **Full transpose:** DIM=5, W=8, size=5, mode=0. Load rows with M[r][c]=r*5+c, valid held high, out_ready high -> out rows are {0,5,10,15,20}, {1,6,11,16,21}, ... {4,9,14,19,24}. done is 11 cycles after start; busy is low the cycle after.
- **Passthrough:** mode=1, same input -> out rows are identical to the input rows, in order.
- **Sub-matrix:** size=3. Input rows carry nonzero data in columns 3-4 -> only 3 rows accepted, and in_ready drops after the third. Out rows are {0,5,10,0,0}, {1,6,11,0,0}, {2,7,12,0,0}.
- **Backpressure:** toggle in_valid randomly and hold out_ready=0 for 4 cycles in the middle of EMIT -> out_row stable during the stall, no duplicated or dropped rows, same result as the full transpose case.
- **Reset and ignored start:** assert rst after 2 input rows -> next cycle busy=0, in_ready=0, no done. Restart with size=0 -> treated as n=5. A start pulse during EMIT has no effect.
- **Back-to-back jobs:** assert start in the done cycle with size=2, mode=0 -> the second job loads and emits the 2x2 transpose correctly, with buffer residue from the first job not visible.
